// File: rtl/pipemem_ext.sv
// Pipeline memory stage with a byte-addressed data RAM and memory-mapped I/O.
// Stores finish in one cycle. Loads take two cycles: the request cycle
// asserts mstall, and the following LWAIT cycle presents the extended result.
module pipemem_ext #(
    parameter int ADDR_W = 5,
    parameter int N_OUT  = 3,
    parameter int N_IN   = 3,
    parameter int IN_W   = 4,
    parameter int IO_BIT = 7
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     mwmem,
    input  logic                     mrmem,
    input  logic [1:0]               msize,
    input  logic                     munsigned,
    input  logic [31:0]              malu,
    input  logic [31:0]              mb,
    input  logic [N_IN*IN_W-1:0]     in_port,
    output logic [31:0]              dataout,
    output logic                     mstall,
    output logic                     misalign,
    output logic [N_OUT*32-1:0]      out_port
);

    localparam int IO_W  = IO_BIT - 2;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, LWAIT} state_t;

    state_t                state;
    state_t                next_state;

    logic [31:0]           ram [DEPTH];
    logic [31:0]           out_reg [N_OUT];
    logic [N_IN*IN_W-1:0]  sync1;
    logic [N_IN*IN_W-1:0]  sync2;
    logic [31:0]           rd_reg;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  uns_q;

    logic                  is_io;
    logic [ADDR_W-1:0]     ram_idx;
    logic [IO_W-1:0]       io_idx;
    logic                  bad_align;
    logic [3:0]            byte_en;
    logic [31:0]           wdata;
    logic                  do_store;
    logic                  load_start;
    logic [31:0]           io_rdata;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [31:0]           ext_data;
    logic                  unused_malu;

    assign is_io       = malu[IO_BIT];
    assign ram_idx     = malu[ADDR_W+1:2];
    assign io_idx      = malu[IO_BIT-1:2];
    assign unused_malu = ^malu[31:IO_BIT+1];

    // Alignment fault depends only on size and the low address bits.
    always_comb begin
        bad_align = 1'b0;
        case (msize)
            2'b00:   bad_align = 1'b0;
            2'b01:   bad_align = malu[0];
            2'b10:   bad_align = |malu[1:0];
            default: bad_align = 1'b1;
        endcase
        misalign = (mwmem | mrmem) & bad_align;
    end

    // Lane enables and lane-replicated store data for sub-word stores.
    always_comb begin
        byte_en = 4'b0000;
        wdata   = mb;
        case (msize)
            2'b00: begin
                byte_en = 4'b0001 << malu[1:0];
                wdata   = {4{mb[7:0]}};
            end
            2'b01: begin
                byte_en = malu[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{mb[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wdata   = mb;
            end
            default: begin
                byte_en = 4'b0000;
                wdata   = mb;
            end
        endcase
    end

    // Stores win over loads and are blocked while reset is held.
    assign do_store = mwmem & ~misalign & resetn;

    // I/O read mux: synchronised input ports, zero-extended; unmapped reads 0.
    always_comb begin
        io_rdata = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (io_idx == IO_W'(k)) begin
                io_rdata[IN_W-1:0] = sync2[k*IN_W +: IN_W];
            end
        end
    end

    // Next-state logic: an aligned, store-free load in IDLE stalls one cycle.
    always_comb begin
        next_state = state;
        mstall     = 1'b0;
        load_start = 1'b0;
        case (state)
            IDLE: begin
                if (resetn && mrmem && !mwmem && !misalign) begin
                    load_start = 1'b1;
                    mstall     = 1'b1;
                    next_state = LWAIT;
                end
            end
            LWAIT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Read register captures the raw word plus the extraction controls.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_reg <= '0;
            off_q  <= '0;
            size_q <= '0;
            uns_q  <= 1'b0;
        end else if (load_start) begin
            rd_reg <= is_io ? io_rdata : ram[ram_idx];
            off_q  <= malu[1:0];
            size_q <= msize;
            uns_q  <= munsigned;
        end
    end

    // Data RAM byte-lane writes; reset leaves contents untouched.
    always_ff @(posedge clock) begin
        if (do_store && !is_io) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    ram[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Output port registers; writes to unmapped I/O indices fall through.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int j = 0; j < N_OUT; j++) begin
                out_reg[j] <= '0;
            end
        end else if (do_store && is_io) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (io_idx == IO_W'(j)) begin
                    for (int i = 0; i < 4; i++) begin
                        if (byte_en[i]) begin
                            out_reg[j][8*i +: 8] <= wdata[8*i +: 8];
                        end
                    end
                end
            end
        end
    end

    // Two-flop synchroniser on every input port.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Extraction and extension of the captured word, visible only in LWAIT.
    always_comb begin
        byte_sel = rd_reg[8*off_q +: 8];
        half_sel = off_q[1] ? rd_reg[31:16] : rd_reg[15:0];
        case (size_q)
            2'b00:   ext_data = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   ext_data = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: ext_data = rd_reg;
        endcase
        dataout = (state == LWAIT) ? ext_data : 32'b0;
    end

    // Flatten the output registers onto the port bus.
    for (genvar j = 0; j < N_OUT; j++) begin : g_out
        assign out_port[j*32 +: 32] = out_reg[j];
    end

endmodule

// File: tb/tb_pipemem_ext.sv
// Scoreboard bench for pipemem_ext: load requests push their expected result,
// and a monitor pops and compares in the cycle after mstall was seen high.
module tb_pipemem_ext;

    logic         clock;
    logic         resetn;
    logic         mwmem;
    logic         mrmem;
    logic [1:0]   msize;
    logic         munsigned;
    logic [31:0]  malu;
    logic [31:0]  mb;
    logic [11:0]  in_port;
    logic [31:0]  dataout;
    logic         mstall;
    logic         misalign;
    logic [95:0]  out_port;

    int           checks;
    int           failures;
    logic [31:0]  exp_q[$];
    logic         pending;

    pipemem_ext dut (
        .clock     (clock),
        .resetn    (resetn),
        .mwmem     (mwmem),
        .mrmem     (mrmem),
        .msize     (msize),
        .munsigned (munsigned),
        .malu      (malu),
        .mb        (mb),
        .in_port   (in_port),
        .dataout   (dataout),
        .mstall    (mstall),
        .misalign  (misalign),
        .out_port  (out_port)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic w, input logic r, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] data);
        mwmem     = w;
        mrmem     = r;
        msize     = sz;
        munsigned = uns;
        malu      = addr;
        mb        = data;
    endtask

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic doStore(input string name, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] data, input logic exp_mis, input logic also_read);
        @(posedge clock); #1;
        applyStimulus(1'b1, also_read, sz, 1'b0, addr, data);
        @(negedge clock);
        checkOutput({name, "_stall"}, 96'(mstall), 96'(0));
        checkOutput({name, "_misalign"}, 96'(misalign), 96'(exp_mis));
        @(posedge clock); #1;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic doLoad(input string name, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] expected);
        @(posedge clock); #1;
        applyStimulus(1'b0, 1'b1, sz, uns, addr, 32'h0);
        exp_q.push_back(expected);
        @(negedge clock);
        checkOutput({name, "_stall_req"}, 96'(mstall), 96'(1));
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput({name, "_stall_drop"}, 96'(mstall), 96'(0));
        @(posedge clock); #1;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic doMisLoad(input string name, input logic [1:0] sz, input logic [31:0] addr);
        @(posedge clock); #1;
        applyStimulus(1'b0, 1'b1, sz, 1'b0, addr, 32'h0);
        @(negedge clock);
        checkOutput({name, "_misalign"}, 96'(misalign), 96'(1));
        checkOutput({name, "_stall"}, 96'(mstall), 96'(0));
        @(posedge clock); #1;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    // Monitor: the cycle after a stall is the result cycle; pop and compare.
    initial begin
        pending = 1'b0;
        forever begin
            @(negedge clock);
            if (pending) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb_unexpected: got result %h expected no load in flight", dataout);
                end else begin
                    checkOutput("sb_dataout", 96'(dataout), 96'(exp_q.pop_front()));
                end
            end
            pending = mstall;
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        in_port  = 12'h000;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst_dataout", 96'(dataout), 96'(0));
        checkOutput("rst_mstall", 96'(mstall), 96'(0));
        checkOutput("rst_out_port", out_port, 96'(0));
        @(posedge clock); #1;
        resetn = 1'b1;

        // RAM fill and sub-word loads.
        doStore("sw_10", 2'b10, 32'h10, 32'h8899AABB, 1'b0, 1'b0);
        doStore("sw_00", 2'b10, 32'h00, 32'h11223344, 1'b0, 1'b0);
        doStore("sw_0c", 2'b10, 32'h0C, 32'hCAFEF00D, 1'b0, 1'b0);
        doLoad("lbu_11", 2'b00, 1'b1, 32'h11, 32'h000000AA);
        doLoad("lb_13",  2'b00, 1'b0, 32'h13, 32'hFFFFFF88);
        doLoad("lh_12",  2'b01, 1'b0, 32'h12, 32'hFFFF8899);
        doLoad("lhu_10", 2'b01, 1'b1, 32'h10, 32'h0000AABB);
        doLoad("lw_10",  2'b10, 1'b0, 32'h10, 32'h8899AABB);

        // I/O stores, including an unmapped index.
        doStore("sb_81", 2'b00, 32'h81, 32'h0000005A, 1'b0, 1'b0);
        checkOutput("out_after_sb", out_port, 96'h00000000_00000000_00005A00);
        doStore("sh_86", 2'b01, 32'h86, 32'h00001234, 1'b0, 1'b0);
        doStore("sw_8c", 2'b10, 32'h8C, 32'hDEADBEEF, 1'b0, 1'b0);
        checkOutput("out_after_io", out_port, 96'h00000000_12340000_00005A00);
        doLoad("lw_00_kept", 2'b10, 1'b0, 32'h00, 32'h11223344);
        doLoad("lw_0c_kept", 2'b10, 1'b0, 32'h0C, 32'hCAFEF00D);

        // Input ports through the synchroniser.
        @(posedge clock); #1;
        in_port = 12'h590;
        @(posedge clock);
        doLoad("in_84", 2'b10, 1'b0, 32'h84, 32'h00000009);
        doLoad("in_88", 2'b10, 1'b0, 32'h88, 32'h00000005);
        doLoad("in_8c", 2'b10, 1'b0, 32'h8C, 32'h00000000);

        // Misaligned accesses.
        doMisLoad("lw_12", 2'b10, 32'h12);
        doMisLoad("sz11_10", 2'b11, 32'h10);
        doStore("sh_13", 2'b01, 32'h13, 32'h0000FFFF, 1'b1, 1'b0);
        doStore("sh_83", 2'b01, 32'h83, 32'h0000FFFF, 1'b1, 1'b0);
        checkOutput("out_after_mis", out_port, 96'h00000000_12340000_00005A00);
        doLoad("lw_10_nomis", 2'b10, 1'b0, 32'h10, 32'h8899AABB);

        // Store and load together: store wins, no stall.
        doStore("swlw_14", 2'b10, 32'h14, 32'h0BADF00D, 1'b0, 1'b1);
        doLoad("lw_14", 2'b10, 1'b0, 32'h14, 32'h0BADF00D);

        // Reset asserted during LWAIT, then a store while reset is held.
        @(posedge clock); #1;
        applyStimulus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
        exp_q.push_back(32'h8899AABB);
        @(negedge clock);
        checkOutput("rl_stall_req", 96'(mstall), 96'(1));
        @(posedge clock); #1;
        resetn = 1'b0;
        @(negedge clock);
        checkOutput("rl_lwait_stall", 96'(mstall), 96'(0));
        @(posedge clock); #1;
        @(negedge clock);
        checkOutput("rl_after_dataout", 96'(dataout), 96'(0));
        checkOutput("rl_after_stall", 96'(mstall), 96'(0));
        checkOutput("rl_after_out", out_port, 96'(0));
        @(posedge clock); #1;
        applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h80, 32'hFFFFFFFF);
        @(posedge clock); #1;
        resetn = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        checkOutput("rst_store_blocked", out_port, 96'(0));
        doLoad("lw_10_after_rst", 2'b10, 1'b0, 32'h10, 32'h8899AABB);

        repeat (3) @(posedge clock);
        checkOutput("sb_queue_empty", 96'(exp_q.size()), 96'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
